// File: rtl/alarm_set_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// alarm_set_if - button/time/display bundle around alarm_set_ctrl. Rev 1.0
//------------------------------------------------------------------------------
interface alarm_set_if;
  logic       tick_1hz;
  logic       btn_mode;
  logic       btn_up;
  logic       btn_down;
  logic       btn_alarm;
  logic [3:0] cur_hr_10s;
  logic [3:0] cur_hr_1s;
  logic [3:0] cur_min_10s;
  logic [3:0] cur_min_1s;
  logic [3:0] disp_hr_10s;
  logic [3:0] disp_hr_1s;
  logic [3:0] disp_min_10s;
  logic [3:0] disp_min_1s;
  logic [3:0] alarm_hr_10s;
  logic [3:0] alarm_hr_1s;
  logic [3:0] alarm_min_10s;
  logic [3:0] alarm_min_1s;
  logic [7:0] digit_blank;
  logic       set_load;
  logic [3:0] set_hr_10s;
  logic [3:0] set_hr_1s;
  logic [3:0] set_min_10s;
  logic [3:0] set_min_1s;
  logic       alarm_status;
  logic       ringing;

  modport master (
    output tick_1hz, btn_mode, btn_up, btn_down, btn_alarm,
           cur_hr_10s, cur_hr_1s, cur_min_10s, cur_min_1s,
    input  disp_hr_10s, disp_hr_1s, disp_min_10s, disp_min_1s,
           alarm_hr_10s, alarm_hr_1s, alarm_min_10s, alarm_min_1s,
           digit_blank, set_load, set_hr_10s, set_hr_1s, set_min_10s, set_min_1s,
           alarm_status, ringing
  );

  modport slave (
    input  tick_1hz, btn_mode, btn_up, btn_down, btn_alarm,
           cur_hr_10s, cur_hr_1s, cur_min_10s, cur_min_1s,
    output disp_hr_10s, disp_hr_1s, disp_min_10s, disp_min_1s,
           alarm_hr_10s, alarm_hr_1s, alarm_min_10s, alarm_min_1s,
           digit_blank, set_load, set_hr_10s, set_hr_1s, set_min_10s, set_min_1s,
           alarm_status, ringing
  );
endinterface
`default_nettype wire

// File: rtl/alarm_set_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// alarm_set_ctrl - mode/edit sequencing, field blink and alarm ring control. Rev 1.0
//------------------------------------------------------------------------------
module alarm_set_ctrl #(
  parameter int BLINK_CYCLES = 50_000_000,
  parameter int RING_TICKS   = 60
) (
  input wire         clk,
  input wire         reset_n,
  alarm_set_if.slave bus
);

  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam int RW = $clog2(RING_TICKS + 1);

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    SET_HR  = 3'd1,
    SET_MIN = 3'd2,
    ALM_HR  = 3'd3,
    ALM_MIN = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      edit_hr_q, edit_hr_d, edit_min_q, edit_min_d;
  logic [7:0]      alm_hr_q, alm_hr_d, alm_min_q, alm_min_d;
  logic [7:0]      set_hr_q, set_hr_d, set_min_q, set_min_d;
  logic            set_load_q, set_load_d;
  logic            armed_q, armed_d;
  logic            ringing_q, ringing_d;
  logic [RW-1:0]   ring_cnt_q, ring_cnt_d;
  logic            match_q, match_d, match_dly_q, match_dly_d;
  logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
  logic            blink_phase_q, blink_phase_d;
  logic [15:0]     disp_q, disp_d;
  logic [7:0]      blank_q, blank_d;

  logic [7:0]      cur_hr, cur_min;
  logic            any_btn, ack, step, step_ok;

  // Increment/decrement a packed two-digit BCD value, wrapping between 00 and top.
  function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic inc,
                                          input logic [7:0] top);
    logic [7:0] r;
    if (inc) begin
      if (v == top)              r = 8'h00;
      else if (v[3:0] == 4'd9)   r = {v[7:4] + 4'd1, 4'd0};
      else                       r = {v[7:4], v[3:0] + 4'd1};
    end else begin
      if (v == 8'h00)            r = top;
      else if (v[3:0] == 4'd0)   r = {v[7:4] - 4'd1, 4'd9};
      else                       r = {v[7:4], v[3:0] - 4'd1};
    end
    return r;
  endfunction

  always_comb begin
    state_d       = state_q;
    edit_hr_d     = edit_hr_q;
    edit_min_d    = edit_min_q;
    alm_hr_d      = alm_hr_q;
    alm_min_d     = alm_min_q;
    set_hr_d      = set_hr_q;
    set_min_d     = set_min_q;
    set_load_d    = 1'b0;
    armed_d       = armed_q;
    ringing_d     = ringing_q;
    ring_cnt_d    = ring_cnt_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    blank_d       = 8'h00;
    step_ok       = 1'b0;

    cur_hr  = {bus.cur_hr_10s, bus.cur_hr_1s};
    cur_min = {bus.cur_min_10s, bus.cur_min_1s};
    any_btn = bus.btn_mode | bus.btn_up | bus.btn_down | bus.btn_alarm;
    ack     = ringing_q & any_btn;
    step    = bus.btn_up ^ bus.btn_down;

    // A press that silences the ring does nothing else.
    if (!ack) begin
      if (bus.btn_mode) begin
        case (state_q)
          RUN: begin
            state_d    = SET_HR;
            edit_hr_d  = cur_hr;
            edit_min_d = cur_min;
          end
          SET_HR:  state_d = SET_MIN;
          SET_MIN: begin
            state_d    = ALM_HR;
            set_load_d = 1'b1;
            set_hr_d   = edit_hr_q;
            set_min_d  = edit_min_q;
          end
          ALM_HR:  state_d = ALM_MIN;
          default: state_d = RUN;
        endcase
      end else begin
        if (step) begin
          step_ok = 1'b1;
          case (state_q)
            SET_HR:  edit_hr_d  = bcd_step(edit_hr_q,  bus.btn_up, 8'h23);
            SET_MIN: edit_min_d = bcd_step(edit_min_q, bus.btn_up, 8'h59);
            ALM_HR:  alm_hr_d   = bcd_step(alm_hr_q,   bus.btn_up, 8'h23);
            ALM_MIN: alm_min_d  = bcd_step(alm_min_q,  bus.btn_up, 8'h59);
            default: step_ok    = 1'b0;
          endcase
        end
        if (bus.btn_alarm && state_q == RUN) armed_d = ~armed_q;
      end
    end

    if (step_ok || state_d != state_q) begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b0;
    end else if (blink_cnt_q == BW'(BLINK_CYCLES - 1)) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end else begin
      blink_cnt_d   = blink_cnt_q + BW'(1);
    end

    if (blink_phase_d) begin
      case (state_d)
        SET_HR:  blank_d = 8'hC0;
        SET_MIN: blank_d = 8'h30;
        ALM_HR:  blank_d = 8'h0C;
        ALM_MIN: blank_d = 8'h03;
        default: blank_d = 8'h00;
      endcase
    end

    disp_d = (state_d == SET_HR || state_d == SET_MIN) ? {edit_hr_d, edit_min_d}
                                                       : {cur_hr, cur_min};

    match_d     = armed_q && state_q == RUN && cur_hr == alm_hr_q && cur_min == alm_min_q;
    match_dly_d = match_q;

    // ring_cnt_q holds the ticks already seen in this ring.
    if (ringing_q) begin
      if (any_btn) begin
        ringing_d = 1'b0;
      end else if (bus.tick_1hz) begin
        if (ring_cnt_q == RW'(RING_TICKS - 1)) ringing_d  = 1'b0;
        else                                   ring_cnt_d = ring_cnt_q + RW'(1);
      end
    end else if (match_q && !match_dly_q) begin
      ringing_d  = 1'b1;
      ring_cnt_d = '0;
    end
    if (!armed_d || state_d != RUN) ringing_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= RUN;
      edit_hr_q     <= 8'h00;
      edit_min_q    <= 8'h00;
      alm_hr_q      <= 8'h00;
      alm_min_q     <= 8'h00;
      set_hr_q      <= 8'h00;
      set_min_q     <= 8'h00;
      set_load_q    <= 1'b0;
      armed_q       <= 1'b0;
      ringing_q     <= 1'b0;
      ring_cnt_q    <= '0;
      match_q       <= 1'b0;
      match_dly_q   <= 1'b0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      disp_q        <= 16'h0000;
      blank_q       <= 8'h00;
    end else begin
      state_q       <= state_d;
      edit_hr_q     <= edit_hr_d;
      edit_min_q    <= edit_min_d;
      alm_hr_q      <= alm_hr_d;
      alm_min_q     <= alm_min_d;
      set_hr_q      <= set_hr_d;
      set_min_q     <= set_min_d;
      set_load_q    <= set_load_d;
      armed_q       <= armed_d;
      ringing_q     <= ringing_d;
      ring_cnt_q    <= ring_cnt_d;
      match_q       <= match_d;
      match_dly_q   <= match_dly_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      disp_q        <= disp_d;
      blank_q       <= blank_d;
    end
  end

  assign bus.disp_hr_10s   = disp_q[15:12];
  assign bus.disp_hr_1s    = disp_q[11:8];
  assign bus.disp_min_10s  = disp_q[7:4];
  assign bus.disp_min_1s   = disp_q[3:0];
  assign bus.alarm_hr_10s  = alm_hr_q[7:4];
  assign bus.alarm_hr_1s   = alm_hr_q[3:0];
  assign bus.alarm_min_10s = alm_min_q[7:4];
  assign bus.alarm_min_1s  = alm_min_q[3:0];
  assign bus.digit_blank   = blank_q;
  assign bus.set_load      = set_load_q;
  assign bus.set_hr_10s    = set_hr_q[7:4];
  assign bus.set_hr_1s     = set_hr_q[3:0];
  assign bus.set_min_10s   = set_min_q[7:4];
  assign bus.set_min_1s    = set_min_q[3:0];
  assign bus.alarm_status  = armed_q;
  assign bus.ringing       = ringing_q;

endmodule
`default_nettype wire
